// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage with register file, WB bypass, load-use stall and ID/EX handshake register
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int INIT_IDX = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_en_o,
  output logic [1:0]      mem_sig_o,
  output logic [1:0]      br_type_o,
  output logic [3:0]      exe_cmd_o,
  output logic            is_src2_o,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic [XLEN-1:0] reg2_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      dest_o,
  output logic [4:0]      src1_o,
  output logic [4:0]      src2_o,
  output logic            hazard
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef struct packed {
    logic            valid;
    logic            wb;
    logic [1:0]      mem;
    logic [1:0]      br;
    logic [3:0]      cmd;
    logic            src2f;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] pc;
    logic [4:0]      dest;
    logic [4:0]      src1;
    logic [4:0]      src2;
  } entry_t;

  logic [NREGS-1:0][XLEN-1:0] rf_q;
  entry_t          entry_q, entry_d, dec_entry, entry_out;
  logic [5:0]      opcode;
  logic [RW-1:0]   rs_idx, rt_idx, wb_idx;
  logic [XLEN-1:0] rs_val, rt_val;
  logic            wb_fwd, dec_imm, hazard_raw, adv;

  assign opcode = instr[31:26];
  assign rs_idx = instr[21 +: RW];
  assign rt_idx = instr[16 +: RW];
  assign wb_idx = wb_dest[RW-1:0];
  assign wb_fwd = (BYPASS != 0) && wb_en && (wb_idx != '0);

  // Operand read: R0 is hard zero; a same-cycle WB write may be forwarded
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != '0) rs_val = (wb_fwd && (wb_idx == rs_idx)) ? wb_data : rf_q[rs_idx];
    if (rt_idx != '0) rt_val = (wb_fwd && (wb_idx == rt_idx)) ? wb_data : rf_q[rt_idx];
  end

  // Register file: reset image, then WB writes (index 0 never written)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= (INIT_IDX != 0) ? XLEN'(i) : '0;
    end else if (wb_en && (wb_idx != '0)) begin
      rf_q[wb_idx] <= wb_data;
    end
  end

  // Opcode decode into a candidate ID/EX entry
  always_comb begin
    dec_entry = '0;
    dec_imm   = 1'b0;
    case (opcode)
      6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: begin
        dec_entry.wb = 1'b1; dec_entry.src2f = 1'b1;
      end
      6'd32, 6'd33: begin dec_entry.wb = 1'b1; dec_imm = 1'b1; end
      6'd36: begin dec_entry.wb = 1'b1; dec_entry.mem = 2'b10; dec_imm = 1'b1; end
      6'd37: begin dec_entry.mem = 2'b01; dec_imm = 1'b1; dec_entry.src2f = 1'b1; end
      6'd40: begin dec_entry.br = 2'b01; dec_imm = 1'b1; end
      6'd41: begin dec_entry.br = 2'b10; dec_imm = 1'b1; dec_entry.src2f = 1'b1; end
      6'd42: begin dec_entry.br = 2'b11; dec_imm = 1'b1; dec_entry.src2f = 1'b1; end
      default: ;
    endcase
    case (opcode)
      6'd3, 6'd33:  dec_entry.cmd = 4'd2;
      6'd5:         dec_entry.cmd = 4'd4;
      6'd6:         dec_entry.cmd = 4'd5;
      6'd7:         dec_entry.cmd = 4'd6;
      6'd8:         dec_entry.cmd = 4'd7;
      6'd9, 6'd10:  dec_entry.cmd = 4'd8;
      6'd11:        dec_entry.cmd = 4'd9;
      6'd12:        dec_entry.cmd = 4'd10;
      default:      dec_entry.cmd = 4'd0;
    endcase
    dec_entry.valid = 1'b1;
    dec_entry.dest  = dec_imm ? instr[20:16] : instr[15:11];
    dec_entry.src1  = instr[25:21];
    dec_entry.src2  = dec_entry.src2f ? instr[20:16] : 5'd0;
    dec_entry.val1  = rs_val;
    dec_entry.reg2  = rt_val;
    dec_entry.val2  = dec_imm ? {{(XLEN-16){instr[15]}}, instr[15:0]} : rt_val;
    dec_entry.pc    = pc_in;
  end

  // Load-use detection against the load currently held in ID/EX
  always_comb begin
    hazard_raw = in_valid && entry_q.valid && (entry_q.mem == 2'b10) && (entry_q.dest != 5'd0) &&
                 ((entry_q.dest == instr[25:21]) || (dec_entry.src2f && (entry_q.dest == instr[20:16])));
  end

  assign adv      = ~entry_q.valid | out_ready;
  assign hazard   = ~rst & hazard_raw;
  assign in_ready = ~rst & adv & ~hazard_raw & ~flush;

  // ID/EX next state: flush kills, otherwise advance with a bubble or the new entry
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = '0;
    end else if (adv) begin
      entry_d = '0;
      if (!hazard_raw && in_valid) entry_d = dec_entry;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign entry_out = rst ? '0 : entry_q;
  assign out_valid = entry_out.valid;
  assign wb_en_o   = entry_out.wb;
  assign mem_sig_o = entry_out.mem;
  assign br_type_o = entry_out.br;
  assign exe_cmd_o = entry_out.cmd;
  assign is_src2_o = entry_out.src2f;
  assign val1_o    = entry_out.val1;
  assign val2_o    = entry_out.val2;
  assign reg2_o    = entry_out.reg2;
  assign pc_o      = entry_out.pc;
  assign dest_o    = entry_out.dest;
  assign src1_o    = entry_out.src1;
  assign src2_o    = entry_out.src2;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_en, out_ready;
  logic [31:0] instr, pc_in, wb_data;
  logic [4:0]  wb_dest;

  logic        in_ready, out_valid, wb_en_o, is_src2_o, hazard;
  logic [1:0]  mem_sig_o, br_type_o;
  logic [3:0]  exe_cmd_o;
  logic [31:0] val1_o, val2_o, reg2_o, pc_o;
  logic [4:0]  dest_o, src1_o, src2_o;

  logic        nb_in_ready, nb_out_valid, nb_wb_en_o, nb_is_src2_o, nb_hazard;
  logic [1:0]  nb_mem_sig_o, nb_br_type_o;
  logic [3:0]  nb_exe_cmd_o;
  logic [31:0] nb_val1_o, nb_val2_o, nb_reg2_o, nb_pc_o;
  logic [4:0]  nb_dest_o, nb_src1_o, nb_src2_o;

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .INIT_IDX(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .wb_en_o(wb_en_o), .mem_sig_o(mem_sig_o), .br_type_o(br_type_o),
    .exe_cmd_o(exe_cmd_o), .is_src2_o(is_src2_o), .val1_o(val1_o), .val2_o(val2_o), .reg2_o(reg2_o),
    .pc_o(pc_o), .dest_o(dest_o), .src1_o(src1_o), .src2_o(src2_o), .hazard(hazard));

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .INIT_IDX(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .instr(instr), .pc_in(pc_in),
    .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(nb_out_valid),
    .out_ready(out_ready), .wb_en_o(nb_wb_en_o), .mem_sig_o(nb_mem_sig_o), .br_type_o(nb_br_type_o),
    .exe_cmd_o(nb_exe_cmd_o), .is_src2_o(nb_is_src2_o), .val1_o(nb_val1_o), .val2_o(nb_val2_o),
    .reg2_o(nb_reg2_o), .pc_o(nb_pc_o), .dest_o(nb_dest_o), .src1_o(nb_src1_o), .src2_o(nb_src2_o),
    .hazard(nb_hazard));

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [1:0]  mem, br;
    logic [3:0]  cmd;
    logic        src2f;
    logic [31:0] val1, val2, reg2, pc;
    logic [4:0]  dest, src1, src2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_rf [32];
  int          n_vec = 0;
  int          n_fail = 0;
  bit          accepted;
  logic [5:0]  ops [20] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                            6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd2, 6'd63};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && (wb_dest == idx)) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [5:0] op;
    logic       is_r, use_imm;
    op      = ins[31:26];
    is_r    = op inside {6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};
    use_imm = op inside {6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42};
    e.wb    = is_r || (op inside {6'd32, 6'd33, 6'd36});
    e.src2f = is_r || (op inside {6'd37, 6'd41, 6'd42});
    e.mem   = (op == 6'd36) ? 2'b10 : (op == 6'd37) ? 2'b01 : 2'b00;
    e.br    = (op == 6'd40) ? 2'b01 : (op == 6'd41) ? 2'b10 : (op == 6'd42) ? 2'b11 : 2'b00;
    case (op)
      6'd3, 6'd33: e.cmd = 4'd2;
      6'd5:        e.cmd = 4'd4;
      6'd6:        e.cmd = 4'd5;
      6'd7:        e.cmd = 4'd6;
      6'd8:        e.cmd = 4'd7;
      6'd9, 6'd10: e.cmd = 4'd8;
      6'd11:       e.cmd = 4'd9;
      6'd12:       e.cmd = 4'd10;
      default:     e.cmd = 4'd0;
    endcase
    e.dest = use_imm ? ins[20:16] : ins[15:11];
    e.src1 = ins[25:21];
    e.src2 = e.src2f ? ins[20:16] : 5'd0;
    e.val1 = m_read(ins[25:21]);
    e.reg2 = m_read(ins[20:16]);
    e.val2 = use_imm ? {{16{ins[15]}}, ins[15:0]} : e.reg2;
    e.pc   = pc;
    return e;
  endfunction

  task automatic sb_cycle();
    exp_t e;
    accepted = 1'b0;
    if (rst) begin
      sb_q.delete();
      return;
    end
    if (out_valid && (out_ready || flush)) begin
      if (sb_q.size() == 0) begin
        chk("sb_stray_output", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wb_en", wb_en_o, e.wb);
        chk("sb_mem_sig", mem_sig_o, e.mem);
        chk("sb_br_type", br_type_o, e.br);
        chk("sb_exe_cmd", exe_cmd_o, e.cmd);
        chk("sb_is_src2", is_src2_o, e.src2f);
        chk("sb_val1", val1_o, e.val1);
        chk("sb_val2", val2_o, e.val2);
        chk("sb_reg2", reg2_o, e.reg2);
        chk("sb_pc", pc_o, e.pc);
        chk("sb_dest", dest_o, e.dest);
        chk("sb_src1", src1_o, e.src1);
        chk("sb_src2", src2_o, e.src2);
      end
    end
    if (in_valid && in_ready) begin
      sb_q.push_back(predict(instr, pc_in));
      accepted = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
    end else if (wb_en && (wb_dest != 5'd0)) begin
      m_rf[wb_dest] = wb_data;
    end
    #1;
  endtask

  initial begin
    int tries;
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    step(); step();
    chk("rst_out_valid2", out_valid, 0);
    chk("rst_val1", val1_o, 0);
    chk("rst_dest", dest_o, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_in_ready2", in_ready, 0);
    rst = 1'b0;

    in_valid = 1'b1; instr = mk_r(6'd1, 5'd3, 5'd4, 5'd5); pc_in = 32'h104;
    #1 chk("add_in_ready", in_ready, 1);
    step();
    chk("add_out_valid", out_valid, 1);
    chk("add_val1", val1_o, 3);
    chk("add_val2", val2_o, 4);
    chk("add_dest", dest_o, 5);
    chk("add_cmd", exe_cmd_o, 0);
    chk("add_wb", wb_en_o, 1);

    instr = mk_i(6'd32, 5'd2, 5'd6, 16'hFFFE); pc_in = 32'h108;
    step();
    chk("addi_val1", val1_o, 2);
    chk("addi_val2", val2_o, 32'hFFFF_FFFE);
    chk("addi_dest", dest_o, 6);
    chk("addi_src2", src2_o, 0);
    chk("addi_is_src2", is_src2_o, 0);

    instr = mk_i(6'd36, 5'd1, 5'd7, 16'h0004); pc_in = 32'h10C;
    step();
    chk("ld_out_valid", out_valid, 1);
    chk("ld_mem_sig", mem_sig_o, 2);
    instr = mk_r(6'd1, 5'd7, 5'd1, 5'd8); pc_in = 32'h110;
    #1;
    chk("lu_hazard", hazard, 1);
    chk("lu_in_ready", in_ready, 0);
    step();
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_hazard_clear", hazard, 0);
    chk("lu_in_ready_back", in_ready, 1);
    step();
    chk("lu_dep_valid", out_valid, 1);
    chk("lu_dep_dest", dest_o, 8);
    chk("lu_dep_val1", val1_o, 7);

    out_ready = 1'b0; instr = mk_r(6'd3, 5'd1, 5'd2, 5'd3); pc_in = 32'h114;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_dest", dest_o, 8);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_next_dest", dest_o, 3);
    chk("bp_next_cmd", exe_cmd_o, 2);

    out_ready = 1'b0; flush = 1'b1; instr = mk_r(6'd8, 5'd1, 5'd2, 5'd4); pc_in = 32'h118;
    #1 chk("fl_in_ready", in_ready, 0);
    step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_dest", dest_o, 0);
    chk("fl_val1", val1_o, 0);
    chk("fl_cmd", exe_cmd_o, 0);
    chk("fl_pc", pc_o, 0);
    chk("fl_wb", wb_en_o, 0);
    flush = 1'b0; out_ready = 1'b1;

    instr = mk_r(6'd1, 5'd9, 5'd0, 5'd10); pc_in = 32'h11C;
    wb_en = 1'b1; wb_dest = 5'd9; wb_data = 32'hABCD;
    step();
    chk("byp_val1", val1_o, 32'hABCD);
    chk("nobyp_val1", nb_val1_o, 9);
    wb_en = 1'b0;
    step();
    chk("byp_after_val1", val1_o, 32'hABCD);
    chk("nobyp_after_val1", nb_val1_o, 32'hABCD);
    wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'h5555; instr = mk_r(6'd1, 5'd0, 5'd0, 5'd1);
    step();
    chk("r0_byp_val1", val1_o, 0);
    chk("r0_nobyp_val1", nb_val1_o, 0);
    wb_en = 1'b0;
    step();
    chk("r0_kept_val1", val1_o, 0);
    chk("r0_kept_val2", val2_o, 0);

    for (int k = 0; k < 20; k++) begin
      instr = {ops[k], 26'($urandom)};
      pc_in = $urandom;
      tries = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        wb_en     = 1'($urandom);
        wb_dest   = 5'($urandom);
        wb_data   = $urandom;
        step();
        tries++;
      end while (!accepted && tries < 20);
      if (!accepted) chk("rand_accept_timeout", 0, 1);
    end

    wb_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; instr = mk_r(6'd5, 5'd1, 5'd2, 5'd3);
    step(); step();
    chk("stall_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_ready", in_ready, 0);
    chk("rst_stall_hazard", hazard, 0);
    step();
    rst = 1'b0;
    #1 chk("rst_discard_valid", out_valid, 0);
    out_ready = 1'b1; instr = mk_r(6'd1, 5'd9, 5'd9, 5'd2);
    step();
    chk("reinit_val1", val1_o, 9);
    chk("reinit_val2", val2_o, 9);

    in_valid = 1'b0;
    step(); step();
    chk("sb_drain", sb_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised successor to the fixed 32×32 decode stage. Decodes one instruction per cycle, reads operands from an internal register file with WB write-through bypass, and holds the result in an ID/EX pipeline register. Adds valid/ready handshakes on both sides and self-contained load-use hazard detection. Sits between the IF stage register and the EXE stage.

## Interface
Parameters:
- XLEN, 32, data/PC width (≥16)
- NREGS, 32, register count (power of 2, 2..32); RW = log2(NREGS), register index taken from low RW bits of each 5-bit field
- INIT_IDX, 1, reset value of register i: 1 → i, 0 → 0
- BYPASS, 1, 1 → same-cycle WB write visible to the decode read

Ports:
- clk  in  1  clock; everything on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instr/pc_in valid
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- instr  in  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
- pc_in  in  XLEN  PC+4 of instr
- flush  in  1  branch-taken kill
- wb_en, wb_dest[4:0], wb_data[XLEN]  in  write-back port
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  EXE accepts entry
- wb_en_o 1, mem_sig_o 2, br_type_o 2, exe_cmd_o 4, is_src2_o 1  out  control
- val1_o, val2_o, reg2_o, pc_o  out  XLEN  operands / PC
- dest_o, src1_o, src2_o  out  5  destination, forwarding sources
- hazard  out  1  load-use stall active (combinational)

## Operation
- Decode (opcode → wb,mem,br,cmd,imm,src2): 0 NOP all 0; 1 ADD cmd0; 3 SUB cmd2; 5 AND cmd4; 6 OR cmd5; 7 NOR cmd6; 8 XOR cmd7; 9 SLA/10 SLL cmd8; 11 SRA cmd9; 12 SRL cmd10 (all R-type: wb=1, imm=0, src2=1); 32 ADDI cmd0, 33 SUBI cmd2 (wb=1, imm=1, src2=0); 36 LD wb=1 mem=10 imm=1; 37 ST mem=01 imm=1 src2=1; 40 BEZ br=01 imm=1; 41 BNE br=10 imm=1 src2=1; 42 JMP br=11 imm=1 src2=1; others = NOP.
- dest = imm ? rt : rd. src1 = rs. src2 = is_src2 ? rt : 0 (ST/BNE now report rt for forwarding).
- val1 = R[rs]; reg2 = R[rt]; val2 = imm ? sign-extend(imm16 → XLEN) : R[rt].
- Register file: write on posedge when wb_en & wb_dest≠0; R0 reads 0 always. BYPASS=1: a read of index == wb_dest (≠0) with wb_en returns wb_data the same cycle.
- Hazard: hazard = in_valid & out_valid & mem_sig_o==10 & dest_o≠0 & (dest_o==src1 | (is_src2 & dest_o==src2)).
- Handshake: adv = ~out_valid | out_ready. in_ready = adv & ~hazard & ~flush.
- ID/EX register update priority: rst > flush > (adv & hazard: load bubble) > (adv & in_valid & in_ready: load decoded entry) > (adv: load bubble) > hold.
- Bubble / flush / reset entry: out_valid=0, all output fields 0.
- While held (out_valid & ~out_ready) outputs stable; instr not consumed.

## Timing
- Latency 1 cycle: accepted at edge N → outputs valid after edge N.
- Throughput 1/cycle absent hazard/backpressure.
- Load-use: exactly one bubble; dependent instruction accepted the following cycle (out then holds the bubble, hazard=0).
- Reset: all outputs 0, out_valid=0, in_ready=0 during rst; registers reinitialised per INIT_IDX. Reset mid-stall discards the held entry.
- flush: entry cleared at next edge regardless of out_ready; incoming instr dropped (in_ready=0).
- WB and decode same register same cycle: BYPASS=1 → new value; BYPASS=0 → old value.
- wb_dest=0 writes ignored.

## Test plan
- Reset, INIT_IDX=1: ADD rs=3 rt=4 rd=5 → next cycle out_valid=1, val1=3, val2=4, dest=5, exe_cmd=0, wb_en_o=1.
- ADDI rs=2 imm=0xFFFE → val2=0xFFFFFFFE, dest=rt, src2_o=0, is_src2_o=0.
- LD dest=7 then ADD rs=7: hazard=1, in_ready=0 one cycle, bubble then ADD; out_valid sequence 1,0,1.
- out_ready=0 for 3 cycles with in_valid=1: outputs frozen, in_ready=0; release → next instruction loads.
- flush with valid entry and out_ready=0 → out_valid=0, all fields 0 next cycle; instr dropped.
- wb_en=1 wb_dest=9 wb_data=0xABCD while decoding rs=9: BYPASS=1 val1=0xABCD; BYPASS=0 val1=9; wb_dest=0 → R0 stays 0.
